// File: rtl/pmc_pkg.sv
// Shared types for the pixel-matrix column deserializer.
// Holds the FSM state encoding used by the top module.
// No logic; types only.
package pmc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    ACTIVE  = 2'd2
  } pmc_deser_state_t;

endpackage

// File: rtl/pmc_deser_lane.sv
// One channel's word assembly register: writes din into the bit selected by bit_idx.
// Latency: the assembled word includes the current sample combinationally; stored on the next edge.
// No backpressure: sampling is fully controlled by the parent FSM.
module pmc_deser_lane #(
  parameter int WORD_W    = 16,
  parameter int MSB_FIRST = 1,
  parameter int IDX_W     = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [IDX_W-1:0]  bit_idx,
  input  logic              din,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  pos;

  // Merge the current sample so a completing bit is visible to the holding register this cycle.
  always_comb begin
    pos  = (MSB_FIRST != 0) ? (IDX_W'(WORD_W - 1) - bit_idx) : bit_idx;
    word = shreg;
    if (sample_en) word[pos] = din;
  end

  // Store the merged word; unsampled bits simply keep stale contents.
  always_ff @(posedge clk) begin
    if (rst) shreg <= '0;
    else     shreg <= word;
  end

endmodule

// File: rtl/pmc_deserializer.sv
// Multi-channel serial-to-parallel receiver for pixel matrix data lines, with word holding register.
// Latency: dout/dout_valid update on the edge ending the last bit's pclk cycle.
// Backpressure: a word completing while the holding register is occupied and not popped is dropped (overrun).
module pmc_deserializer
  import pmc_pkg::*;
#(
  parameter int CHANNELS  = 32,
  parameter int WORD_W    = 16,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sh,
  input  logic                            pclk,
  input  logic [CHANNELS-1:0]             pm_dout,
  input  logic                            clr,
  output logic [CHANNELS-1:0][WORD_W-1:0] dout,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            busy,
  output logic                            overrun,
  output logic                            frame_err,
  output logic [CNT_W-1:0]                words_cnt
);

  localparam int BW = $clog2(WORD_W);
  localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);

  pmc_deser_state_t state, state_next;
  logic [BW-1:0] bit_cnt, cnt_next;
  logic sample_en, complete, abort_word, slot_free;
  logic [CHANNELS-1:0][WORD_W-1:0] assembled;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pmc_deser_lane #(
      .WORD_W   (WORD_W),
      .MSB_FIRST(MSB_FIRST),
      .IDX_W    (BW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .sample_en(sample_en),
      .bit_idx  (bit_cnt),
      .din      (pm_dout[c]),
      .word     (assembled[c])
    );
  end

  // State and bit counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
    end
  end

  // Next-state logic: a strobe always samples first, so a last bit coinciding with sh falling still completes.
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    sample_en  = 1'b0;
    complete   = 1'b0;
    abort_word = 1'b0;
    case (state)
      IDLE: begin
        if (sh) state_next = WAITING;
      end
      WAITING: begin
        if (pclk) begin
          sample_en  = 1'b1;
          cnt_next   = BW'(1);
          state_next = ACTIVE;
        end else if (!sh) begin
          state_next = IDLE;
        end
      end
      ACTIVE: begin
        if (pclk && bit_cnt == LAST) begin
          sample_en  = 1'b1;
          complete   = 1'b1;
          cnt_next   = '0;
          state_next = WAITING;
        end else if (!sh) begin
          sample_en  = pclk;
          abort_word = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else if (pclk) begin
          sample_en = 1'b1;
          cnt_next  = bit_cnt + BW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A same-cycle pop frees the slot for a completing word.
  assign slot_free = !dout_valid || dout_ready;

  // Holding register: load on completion when free, otherwise clear valid on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (complete && slot_free) begin
      dout       <= assembled;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Status flags and word counter; clr wins over same-cycle set/increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      words_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (clr) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
        words_cnt <= '0;
      end else begin
        if (complete && !slot_free) overrun <= 1'b1;
        if (abort_word)             frame_err <= 1'b1;
        if (complete && slot_free)  words_cnt <= words_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pmc_deserializer.md
# pmc_deserializer

Parametrised successor to the pixel-matrix-controller column receiver. It collects serial bits from `CHANNELS` parallel matrix data lines, one bit per `pclk` strobe while `sh` is high, and assembles them into `WORD_W`-bit words per channel with selectable bit order. Complete words go to a valid/ready holding register, with overrun and truncated-word detection and a word counter. It sits between the pixel matrix output pins and the PMC register/DMA side of the SoC.

## Interface
- `CHANNELS`, 32: number of parallel serial data lines (≥1).
- `WORD_W`, 16: bits per word (≥2).
- `MSB_FIRST`, 1: 1 = first received bit lands in bit `WORD_W-1`; 0 = first bit lands in bit 0.
- `CNT_W`, 16: width of `words_cnt`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `sh`  in  1  shift-window enable from the matrix sequencer.
- `pclk`  in  1  bit strobe, synchronous to `clk`; each high cycle is one bit.
- `pm_dout`  in  `CHANNELS`  serial data, sampled in `pclk` cycles.
- `clr`  in  1  synchronous clear of `words_cnt`, `overrun`, `frame_err`.
- `dout`  out  `CHANNELS`×`WORD_W`  holding register, one word per channel.
- `dout_valid`  out  1  holding register contains an unconsumed word.
- `dout_ready`  in  1  consumer accepts `dout` when `dout_valid & dout_ready`.
- `busy`  out  1  state ≠ IDLE.
- `overrun`  out  1  sticky; a completed word was dropped.
- `frame_err`  out  1  sticky; `sh` fell with a partial word.
- `words_cnt`  out  `CNT_W`  words loaded into holding register, wraps.

## Operation
- FSM has three states: IDLE, WAITING, ACTIVE.
- IDLE → WAITING when `sh`=1. `pclk` is ignored in IDLE, including the cycle `sh` rises.
- WAITING:
  - `pclk`=1: sample bit 0, `bit_cnt`←1, go to ACTIVE.
  - else if `sh`=0: go to IDLE.
- ACTIVE:
  - `pclk`=1: sample bit `bit_cnt`.
  - If `bit_cnt`=`WORD_W-1`: word complete, `bit_cnt`←0, go to WAITING. Otherwise `bit_cnt`+1.
  - `sh`=0 with `pclk`=0: discard the partial word, `bit_cnt`←0, set `frame_err`, go to IDLE.
  - `sh`=0 with `pclk`=1: the bit is still sampled first. If that bit completes the word, it is a normal completion; otherwise the abort rule above applies.
- Bit placement for sample index k: bit `WORD_W-1-k` if `MSB_FIRST`, else bit k. This is the same for all channels. Unsampled bits of the shift register keep stale values but are never exposed.
- Word completion, after holding-register pop:
  - If the holding register is free (`!dout_valid` or `dout_ready`): load `dout` with the assembled word, `dout_valid`←1, `words_cnt`+1 (wraps mod 2^`CNT_W`).
  - Else: drop the word, set `overrun`; `dout`, `dout_valid` and `words_cnt` are unchanged.
- Pop without completion: `dout_valid`←0; `dout` holds its value.
- `clr` has priority over same-cycle set and increment: `words_cnt`←0, `overrun`←0, `frame_err`←0. A word loaded in that cycle is still loaded and still valid, but is not counted.
- `bit_cnt` width is `$clog2(WORD_W)`.

## Timing
- Reset values: state IDLE, `bit_cnt` 0, `dout` all 0, `dout_valid` 0, `busy` 0, `overrun` 0, `frame_err` 0, `words_cnt` 0. Reset mid-word discards all progress.
- Earliest first bit: the cycle after `sh` is first seen high.
- Latency: `dout`/`dout_valid` update on the clock edge ending the cycle of the last bit's `pclk`. They are visible one cycle after that strobe.
- Back-to-back `pclk` (every cycle) is supported at one bit per cycle with no bubble between words.
- All outputs are registered.

## Structure
- Package `pmc_pkg`: `pmc_deser_state_t` enum (IDLE, WAITING, ACTIVE).
- Sub-module `pmc_deser_lane`: one channel's `WORD_W` shift/assembly register.
  - Inputs: `sample_en`, `bit_idx`, `din`.
  - Output: assembled word.
  - Instantiated `CHANNELS` times by generate.
- The FSM, holding register, flags and counter stay in the top module.

## Test plan
- Defaults, `sh`=1, 16 consecutive `pclk`, channel 0 pattern 1,0,0,…,0,1 → `dout[0]`=16'h8001 one cycle after the 16th strobe; `dout_valid`=1; `words_cnt`=1.
- `MSB_FIRST`=0, `WORD_W`=8, `CHANNELS`=4, channel 3 bits 1,1,0,0,0,0,0,0 → `dout[3]`=8'h03.
- Two words with `dout_ready`=0 → first word held, `overrun`=1, `words_cnt`=1. Repeat with `dout_ready`=1 on the second word's completion cycle → second word loaded, `overrun`=0, `words_cnt`=2.
- `sh` drops after 5 bits with `pclk`=0 → `frame_err`=1, state IDLE, `dout_valid` unchanged. The next 16-bit window yields a correct word.
- `pclk` high in the same cycle `sh` rises → bit ignored; word assembled from the next 16 strobes.
- `rst` asserted mid-word after 9 bits, then `clr` pulse concurrent with a completion → all outputs at reset values, then `words_cnt`=0 and the new word valid.
